jtopl_pg_chain: RTL and testbench
=================================

# jtopl_pg_chain

Parametrised, time-multiplexed phase-generator accumulator for the OPL core. It owns phase storage for all operator slots, walks them one slot per clock-enable, multiplies the slot's pure phase increment by the MUL factor and adds it to the stored phase. It exposes the operator-phase MSBs to the operator stage and sits between the frequency-number/block decoding and the operator/envelope pipeline.

## Interface
Parameters:
- SLOTS, 18: operator slots in the round-robin; legal range 4..64.
- PHW, 19: stored phase width.
- INCW, 17: pure phase-increment width.
- OPW, 10: operator phase width (top OPW bits of phase).

Ports:
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- cen  in  1  clock enable; one slot is processed per cycle with cen=1.
- mul  in  4  MUL field for the slot currently addressed (cur_slot).
- phinc_pure  in  INCW  pure increment for cur_slot.
- pg_rst  in  1  key-on phase reset for cur_slot.
- freeze  in  1  hold the phase of cur_slot (no increment).
- cur_slot  out  ceil(log2(SLOTS))  slot whose inputs are sampled this cen cycle.
- phase_op  out  OPW  operator phase of slot_op.
- slot_op  out  ceil(log2(SLOTS))  slot that phase_op belongs to.
- zero  out  1  high while slot_op==0.

## Operation
- Slot counter cur_slot runs 0..SLOTS-1 and wraps to 0. It advances only on cen=1.
- Phase store: a circular loop of exactly SLOTS PHW-bit registers. This is (SLOTS-2) shift stages plus the two pipeline registers. There is no RAM, and every slot's phase recirculates once per round.
- Stage 1 (cen cycle t): read the head phase p (the phase of cur_slot). Register p, the factor, phinc_pure, pg_rst and freeze.
- Stage 2 (t+1):
  - prod = phinc_pure * factor, width INCW+5.
  - inc = prod[PHW:1], i.e. product >> 1, truncated to PHW bits.
  - new = pg_rst ? 0 : freeze ? p : (p + inc) mod 2^PHW.
  - new is written into the loop tail.
  - phase_op = new[PHW-1 -: OPW] is registered, and slot_op is set to that slot.
- Factor table by mul 0..15: 1,2,4,6,8,10,12,14,16,18,20,20,24,24,30,30.
- Precedence: pg_rst over freeze over increment.
- Overflow wraps silently modulo 2^PHW.
- cen=0: every register, the counter and the outputs hold.

## Timing
- Reset values: all stored phases 0, cur_slot 0, phase_op 0, slot_op 0, zero 1.
- Latency: inputs sampled with cur_slot=s appear as phase_op/slot_op=s two cen cycles later.
- One result per cen cycle with no bubbles. The round length is SLOTS cen cycles.
- A slot's updated phase is read back exactly SLOTS cen cycles after its previous read. No read-before-write hazard exists for SLOTS>=4.
- rst mid-round clears all slots and restarts at slot 0 on the next cen. Results already in the pipeline are discarded.
- rst and cen are both honoured when coincident; rst wins.

## Structure
- The shared package jtopl_pkg holds the MUL factor table constant and a slot-index width function (clog2).
- One sub-module, jtopl_pg_mulinc (combinational: mul, phinc_pure -> inc), reused by the other PG variants.
- The loop, counter and output registers live in jtopl_pg_chain.

## Test plan
All scenarios use SLOTS=18.
- **Reset:** assert rst for 3 cycles with cen=1 -> phase_op=0, slot_op=0, zero=1, cur_slot=0; the first result after release is slot 0.
- **Basic increment:** slot 5 driven with mul=1, phinc=100; all other slots held with pg_rst=1 -> slot 5's internal phase rises by 100 per round. phase_op for slot 5 stays 0 until phase>=512, i.e. it first reads 1 on the 6th round (phase 600).
- **Truncation:** mul=0 with phinc=1 -> increment 0. mul=0 with phinc=3 -> increment 1 per round.
- **Wrap:** mul=15 with phinc=17'h1FFFF -> increment 393201. From phase 0, the second round gives (786402 mod 524288) = 262114, so phase_op=511.
- **Precedence:** drive pg_rst=1 and freeze=1 together on a slot at a non-zero phase -> next phase 0. freeze alone for 3 rounds -> phase unchanged.
- **cen gating:** toggle cen at 1/3 duty -> results identical to the cen=1 run, indexed by slot. rst mid-round -> all slots return to 0.

Source files
------------

// File: rtl/jtopl_pkg.sv
// Shared constants for the OPL phase-generator blocks: MUL factor table
// and the slot-index width helper.
package jtopl_pkg;

    localparam logic [4:0] MUL_FACTOR [16] = '{
        5'd1,  5'd2,  5'd4,  5'd6,  5'd8,  5'd10, 5'd12, 5'd14,
        5'd16, 5'd18, 5'd20, 5'd20, 5'd24, 5'd24, 5'd30, 5'd30
    };

    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/jtopl_pg_mulinc.sv
// Combinational phase increment: pure increment times MUL factor, halved and
// truncated to the stored phase width.
module jtopl_pg_mulinc
    import jtopl_pkg::*;
#(
    parameter int INCW = 17,
    parameter int PHW  = 19
) (
    input  logic [3:0]      mul_i,
    input  logic [INCW-1:0] phinc_i,
    output logic [PHW-1:0]  inc_o
);

    logic [INCW+4:0] prod;
    logic [INCW+4:0] half;

    always_comb begin
        prod  = (INCW+5)'(phinc_i) * (INCW+5)'(MUL_FACTOR[mul_i]);
        half  = prod >> 1;
        inc_o = PHW'(half);
    end

endmodule

// File: rtl/jtopl_pg_chain.sv
// Time-multiplexed phase accumulator: SLOTS phases circulate through a
// register loop, one slot updated per clock enable.
module jtopl_pg_chain
    import jtopl_pkg::*;
#(
    parameter int SLOTS = 18,
    parameter int PHW   = 19,
    parameter int INCW  = 17,
    parameter int OPW   = 10,
    localparam int SW   = clog2(SLOTS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic [3:0]      mul,
    input  logic [INCW-1:0] phinc_pure,
    input  logic            pg_rst,
    input  logic            freeze,
    output logic [SW-1:0]   cur_slot,
    output logic [OPW-1:0]  phase_op,
    output logic [SW-1:0]   slot_op,
    output logic            zero
);

    localparam int NSH = SLOTS - 2;

    // Loop order: sh_q[0] (head) -> p1_q -> p2_q -> sh_q[NSH-1] (tail) -> ... -> sh_q[0]
    logic [PHW-1:0]  sh_q [NSH];
    logic [PHW-1:0]  p1_q, p2_q, new_d, inc;
    logic [3:0]      mul1_q;
    logic [INCW-1:0] phinc1_q;
    logic            pgrst1_q, freeze1_q;
    logic [SW-1:0]   cur_q, slot1_q, slot_op_q, cur_d;

    jtopl_pg_mulinc #(.INCW(INCW), .PHW(PHW)) u_mulinc (
        .mul_i   (mul1_q),
        .phinc_i (phinc1_q),
        .inc_o   (inc)
    );

    always_comb begin
        new_d = pgrst1_q ? '0 : freeze1_q ? p1_q : p1_q + inc;
        cur_d = (cur_q == SW'(SLOTS - 1)) ? '0 : cur_q + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSH; i++) sh_q[i] <= '0;
            p1_q      <= '0;
            p2_q      <= '0;
            mul1_q    <= '0;
            phinc1_q  <= '0;
            pgrst1_q  <= 1'b0;
            freeze1_q <= 1'b0;
            cur_q     <= '0;
            slot1_q   <= '0;
            slot_op_q <= '0;
        end else if (cen) begin
            for (int i = 0; i < NSH - 1; i++) sh_q[i] <= sh_q[i+1];
            sh_q[NSH-1] <= p2_q;
            p1_q      <= sh_q[0];
            mul1_q    <= mul;
            phinc1_q  <= phinc_pure;
            pgrst1_q  <= pg_rst;
            freeze1_q <= freeze;
            slot1_q   <= cur_q;
            cur_q     <= cur_d;
            p2_q      <= new_d;
            slot_op_q <= slot1_q;
        end
    end

    assign cur_slot = cur_q;
    assign phase_op = p2_q[PHW-1 -: OPW];
    assign slot_op  = slot_op_q;
    assign zero     = (slot_op_q == '0);

endmodule

// File: tb/tb_jtopl_pg_chain.sv
// Directed bench for jtopl_pg_chain with SLOTS=18: per-slot stimulus by round,
// results captured by slot and compared with hand-computed operator phases.
module tb_jtopl_pg_chain;

    localparam int SLOTS = 18;
    localparam int SW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cen = 1'b0;
    logic [3:0]    mul = '0;
    logic [16:0]   phinc_pure = '0;
    logic          pg_rst = 1'b0;
    logic          freeze = 1'b0;
    logic [SW-1:0] cur_slot, slot_op;
    logic [9:0]    phase_op;
    logic          zero;

    jtopl_pg_chain #(.SLOTS(SLOTS), .PHW(19), .INCW(17), .OPW(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .mul        (mul),
        .phinc_pure (phinc_pure),
        .pg_rst     (pg_rst),
        .freeze     (freeze),
        .cur_slot   (cur_slot),
        .phase_op   (phase_op),
        .slot_op    (slot_op),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int tb_slot, tb_round;
    bit clr_mode;
    bit v1;
    int s1, r1;
    int res [1:8][0:17];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stimulus per (slot, round); unlisted slots are held at phase 0.
    task automatic stim(input int s, input int r);
        mul = 4'd0; phinc_pure = '0; pg_rst = 1'b1; freeze = 1'b0;
        if (clr_mode) begin
            pg_rst = 1'b0;
        end else begin
            case (s)
                2:  if (r <= 2) begin mul = 4'd0;  phinc_pure = 17'd1023;   pg_rst = 1'b0; end
                3:  if (r <= 2) begin mul = 4'd0;  phinc_pure = 17'd1025;   pg_rst = 1'b0; end
                5:  begin mul = 4'd1; phinc_pure = 17'd100; pg_rst = (r == 7); freeze = (r == 7); end
                7:  begin
                        mul = 4'd15; phinc_pure = 17'h1FFFF; pg_rst = 1'b0; freeze = (r >= 3);
                    end
                9:  if (r <= 2) begin mul = 4'd11; phinc_pure = 17'd100;    pg_rst = 1'b0; end
                10: if (r <= 2) begin mul = 4'd3;  phinc_pure = 17'd200;    pg_rst = 1'b0; end
                11: begin
                        mul = 4'd13; phinc_pure = 17'd1000; pg_rst = 1'b0; freeze = (r >= 3 && r <= 5);
                    end
                default: ;
            endcase
        end
    endtask

    task automatic clear_res();
        for (int r = 1; r <= 8; r++)
            for (int s = 0; s < SLOTS; s++) res[r][s] = -1;
        v1 = 1'b0; tb_slot = 0; tb_round = 1;
    endtask

    // One clock; with c=1 the bench slot advances and the result pipeline is tracked.
    task automatic step(input bit c);
        cen = c;
        if (c) stim(tb_slot, tb_round);
        else begin
            mul = 4'($urandom_range(0, 15)); phinc_pure = 17'($urandom_range(0, 131071));
            pg_rst = 1'($urandom_range(0, 1)); freeze = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        if (c) begin
            if (v1) begin
                check($sformatf("slot_op r%0d s%0d", r1, s1), 32'(slot_op), 32'(s1));
                check($sformatf("zero r%0d s%0d", r1, s1), 32'(zero), 32'(s1 == 0));
                res[r1][s1] = int'(phase_op);
            end
            v1 = 1'b1; s1 = tb_slot; r1 = tb_round;
            tb_slot = (tb_slot == SLOTS - 1) ? 0 : tb_slot + 1;
            if (tb_slot == 0) tb_round++;
            check("cur_slot", 32'(cur_slot), 32'(tb_slot));
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; cen = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check({tag, " phase_op"}, 32'(phase_op), 32'd0);
        check({tag, " slot_op"},  32'(slot_op),  32'd0);
        check({tag, " zero"},     32'(zero),     32'd1);
        check({tag, " cur_slot"}, 32'(cur_slot), 32'd0);
        rst = 1'b0;
        clear_res();
    endtask

    task automatic chk_res(input string run, input int r, input int s, input int exp);
        check($sformatf("%s phase r%0d s%0d", run, r, s), 32'(res[r][s]), 32'(exp));
    endtask

    task automatic check_run(input string run);
        chk_res(run, 1, 0, 0);
        for (int r = 1; r <= 5; r++) chk_res(run, r, 5, 0);
        chk_res(run, 6, 5, 1);     // phase 600
        chk_res(run, 7, 5, 0);     // pg_rst with freeze
        chk_res(run, 1, 2, 0);     // 1023>>1 = 511
        chk_res(run, 2, 2, 1);
        chk_res(run, 1, 3, 1);     // 1025>>1 = 512
        chk_res(run, 2, 3, 2);
        chk_res(run, 1, 7, 767);   // 393201
        chk_res(run, 2, 7, 511);   // 262114 after wrap
        chk_res(run, 3, 7, 511);   // frozen
        chk_res(run, 1, 9, 1);     // 1000
        chk_res(run, 2, 9, 3);     // 2000
        chk_res(run, 1, 10, 1);    // 600
        chk_res(run, 2, 10, 2);    // 1200
        chk_res(run, 1, 11, 23);   // 12000
        chk_res(run, 2, 11, 46);   // 24000
        for (int r = 3; r <= 5; r++) chk_res(run, r, 11, 46);
        chk_res(run, 6, 11, 70);   // 36000
        chk_res(run, 7, 11, 93);   // 48000
    endtask

    initial begin
        clr_mode = 1'b0;
        clear_res();

        do_reset("reset");
        for (int k = 0; k < 7 * SLOTS + 2; k++) step(1'b1);
        check_run("full");

        do_reset("reset2");
        for (int k = 0; k < 7 * SLOTS + 2; k++) begin
            step(1'b0); step(1'b0); step(1'b1);
        end
        check_run("gated");

        // Mid-round reset with cen low, then recirculate every slot unchanged.
        for (int k = 0; k < 5; k++) step(1'b1);
        rst = 1'b1; cen = 1'b0;
        @(posedge clk); #1;
        check("midrst cur_slot", 32'(cur_slot), 32'd0);
        check("midrst slot_op",  32'(slot_op),  32'd0);
        check("midrst phase_op", 32'(phase_op), 32'd0);
        rst = 1'b0;
        clear_res();
        clr_mode = 1'b1;
        for (int k = 0; k < SLOTS + 2; k++) step(1'b1);
        for (int s = 0; s < SLOTS; s++) chk_res("cleared", 1, s, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
